// File: rtl/burst_mem_pkg.sv
// burst_mem_pkg: shared types and constants for the burst memory responder.
// Holds the FSM state enum, beat geometry and the latency-jitter LFSR constants.
package burst_mem_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_BURST,
    S_REARM
  } state_e;

  localparam int BEATS            = 4;
  localparam int BEAT_W           = 64;
  localparam int BEAT_IDX_W       = 2;
  localparam int LINE_OFFSET_BITS = 5;

  localparam int             LFSR_W    = 4;
  localparam logic [LFSR_W-1:0] LFSR_SEED = 4'b1001;
  // x^4 + x^3 + 1: feedback from bits 3 and 2
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 4'b1100;

  function automatic logic [LFSR_W-1:0] lfsr_step(
    input logic [LFSR_W-1:0] s
  );
    return {s[LFSR_W-2:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/burst_mem_array.sv
// burst_mem_array: line storage as 2^ADDR_BITS x 4 beats of 64 bits.
// One synchronous write port, one combinational read port, no reset.
module burst_mem_array
  import burst_mem_pkg::*;
#(
  parameter int ADDR_BITS = 5
) (
  input  logic                            clk,
  input  logic                            we,
  input  logic [ADDR_BITS+BEAT_IDX_W-1:0] waddr,
  input  logic [BEAT_W-1:0]               wdata,
  input  logic [ADDR_BITS+BEAT_IDX_W-1:0] raddr,
  output logic [BEAT_W-1:0]               rdata
);

  localparam int DEPTH = (2 ** ADDR_BITS) * BEATS;

  logic [BEAT_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/burst_mem_responder.sv
// burst_mem_responder: 4-beat x 64-bit burst memory responder with fixed latency.
// Define BURST_MEM_RANDLAT_EN to add 0..3 LFSR-driven extra wait cycles per request.
module burst_mem_responder
  import burst_mem_pkg::*;
#(
  parameter int ADDR_BITS = 5,
  parameter int LATENCY   = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [31:0]       address_i,
  input  logic              read_i,
  input  logic              write_i,
  input  logic [BEAT_W-1:0] burst_i,
  output logic [BEAT_W-1:0] burst_o,
  output logic              resp_o
);

  localparam int CNT_W = 5;

  state_e                  state, state_nx;
  logic [ADDR_BITS-1:0]    idx, idx_nx;
  logic                    is_rd, is_rd_nx;
  logic [CNT_W-1:0]        cnt, cnt_nx;
  logic [BEAT_IDX_W-1:0]   beat, beat_nx;
  logic [BEAT_IDX_W-1:0]   rd_beat;
  logic                    resp_nx;
  logic [BEAT_W-1:0]       burst_nx;
  logic [BEAT_W-1:0]       rd_data;
  logic                    req;
  logic                    accept;
  logic                    we;
  logic [1:0]              extra;
  logic                    unused_addr;

  assign req = read_i | write_i;

  assign unused_addr = ^{address_i[31:ADDR_BITS+LINE_OFFSET_BITS],
                         address_i[LINE_OFFSET_BITS-1:0]};

`ifdef BURST_MEM_RANDLAT_EN
  logic [LFSR_W-1:0] lfsr;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)    lfsr <= LFSR_SEED;
    else if (accept) lfsr <= lfsr_step(lfsr);
  end

  assign extra = lfsr[1:0];
`else
  assign extra = 2'd0;
`endif

  always_comb begin
    state_nx = state;
    idx_nx   = idx;
    is_rd_nx = is_rd;
    cnt_nx   = cnt;
    beat_nx  = beat;
    resp_nx  = 1'b0;
    burst_nx = '0;
    accept   = 1'b0;
    we       = 1'b0;
    rd_beat  = '0;
    unique case (state)
      S_IDLE: begin
        if (req) begin
          accept   = 1'b1;
          state_nx = S_WAIT;
          idx_nx   = address_i[ADDR_BITS+LINE_OFFSET_BITS-1:LINE_OFFSET_BITS];
          is_rd_nx = read_i;
          cnt_nx   = CNT_W'(LATENCY - 1) + CNT_W'(extra);
        end
      end
      S_WAIT: begin
        if (!req) begin
          state_nx = S_IDLE;
        end else if (cnt == '0) begin
          state_nx = S_BURST;
          beat_nx  = '0;
          resp_nx  = 1'b1;
          burst_nx = is_rd ? rd_data : '0;
        end else begin
          cnt_nx = cnt - CNT_W'(1);
        end
      end
      S_BURST: begin
        we = !is_rd;
        if (beat == BEAT_IDX_W'(BEATS - 1)) begin
          state_nx = S_REARM;
          beat_nx  = '0;
        end else begin
          beat_nx  = beat + BEAT_IDX_W'(1);
          rd_beat  = beat + BEAT_IDX_W'(1);
          resp_nx  = 1'b1;
          burst_nx = is_rd ? rd_data : '0;
        end
      end
      S_REARM: begin
        // one held request must not be serviced twice
        if (!req) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= S_IDLE;
      idx     <= '0;
      is_rd   <= 1'b0;
      cnt     <= '0;
      beat    <= '0;
      resp_o  <= 1'b0;
      burst_o <= '0;
    end else begin
      state   <= state_nx;
      idx     <= idx_nx;
      is_rd   <= is_rd_nx;
      cnt     <= cnt_nx;
      beat    <= beat_nx;
      resp_o  <= resp_nx;
      burst_o <= burst_nx;
    end
  end

  burst_mem_array #(
    .ADDR_BITS(ADDR_BITS)
  ) u_array (
    .clk   (clk),
    .we    (we),
    .waddr ({idx, beat}),
    .wdata (burst_i),
    .raddr ({idx, rd_beat}),
    .rdata (rd_data)
  );

endmodule
